pixel_loader: RTL and testbench

Upstream feed stage for `mainController`. Accepts a raw pixel stream over a valid/ready handshake, binarizes each pixel against a threshold latched at frame start, buffers it in a small FIFO, and issues exactly N*N paced write strobes (`we`/`data_out`) into the skeletonization controller. Signals frame completion so the controller side can begin processing.

---
 rtl/pixel_loader_pkg.sv | 23 ++
 rtl/pixel_loader_fifo.sv | 45 ++++
 rtl/pixel_loader.sv | 138 +++++++++++++
 tb/tb_pixel_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_loader_pkg.sv
// Shared types and helpers for the pixel loader: FSM states and the binarization function.
package pixel_loader_pkg;

   localparam int unsigned MAX_PIX_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } loader_state_t;

   // Threshold to all-ones/zero when enabled, otherwise pass the pixel through.
   function automatic logic [MAX_PIX_W-1:0] binarize_pix(
      input logic [MAX_PIX_W-1:0] pix,
      input logic [MAX_PIX_W-1:0] thr,
      input logic [MAX_PIX_W-1:0] ones,
      input logic                 en
   );
      if (!en) return pix;
      return (pix >= thr) ? ones : '0;
   endfunction

endpackage

// File: rtl/pixel_loader_fifo.sv
// Small synchronous FIFO with combinational head read; push when full and pop when empty are ignored.
module pixel_fifo #(
   parameter int unsigned pixelWidth = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [pixelWidth-1:0] wdata,
   output logic [pixelWidth-1:0] rdata,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [pixelWidth-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q;
   logic [AW:0]           rd_ptr_q;
   logic                  do_push;
   logic                  do_pop;

   // Extra pointer MSB distinguishes full from empty.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/pixel_loader.sv
// Feed stage for the skeletonization controller: accepts a pixel stream, binarizes it,
// buffers it and issues exactly N*N paced write strobes per frame.
module pixel_loader
   import pixel_loader_pkg::*;
#(
   parameter int unsigned N          = 8,
   parameter int unsigned pixelWidth = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WRITE_GAP  = 2,
   parameter int unsigned BINARIZE   = 1,
   localparam int unsigned bitSize   = $clog2(N * N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [pixelWidth-1:0] threshold,
   input  logic                  s_valid,
   input  logic [pixelWidth-1:0] s_data,
   output logic                  s_ready,
   output logic                  we,
   output logic [pixelWidth-1:0] data_out,
   output logic [bitSize:0]      pix_count,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned FRAME_PIXELS = N * N;
   localparam int unsigned CW           = bitSize + 1;
   localparam int unsigned GW           = $clog2(WRITE_GAP + 1);

   loader_state_t         state_q, state_d;
   logic [pixelWidth-1:0] thr_q, thr_d;
   logic [CW-1:0]         in_count_q, in_count_d;
   logic [CW-1:0]         pix_count_q, pix_count_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  we_q, we_d;
   logic [pixelWidth-1:0] data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  frame_done_q, frame_done_d;

   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [pixelWidth-1:0] fifo_rdata, pix_bin;

   // s_ready depends only on registered state so it never loops back through s_valid.
   assign s_ready = (state_q == STREAM) && !fifo_full && (in_count_q < CW'(FRAME_PIXELS));

   assign pix_bin = pixelWidth'(binarize_pix(MAX_PIX_W'(s_data), MAX_PIX_W'(thr_q),
                                             MAX_PIX_W'({pixelWidth{1'b1}}), (BINARIZE != 0)));

   pixel_fifo #(
      .pixelWidth (pixelWidth),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (pix_bin),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         thr_q        <= '0;
         in_count_q   <= '0;
         pix_count_q  <= '0;
         gap_q        <= '0;
         we_q         <= 1'b0;
         data_q       <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         thr_q        <= thr_d;
         in_count_q   <= in_count_d;
         pix_count_q  <= pix_count_d;
         gap_q        <= gap_d;
         we_q         <= we_d;
         data_q       <= data_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      thr_d       = thr_q;
      in_count_d  = in_count_q;
      pix_count_d = pix_count_q;
      gap_d       = gap_q;
      we_d        = 1'b0;
      data_d      = data_q;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = STREAM;
               thr_d       = threshold;
               in_count_d  = '0;
               pix_count_d = '0;
               gap_d       = '0;
            end
         end
         STREAM: begin
            fifo_push = s_valid && s_ready;
            if (fifo_push) in_count_d = in_count_q + CW'(1);
            // Issue: pop the head into the registered output and restart the gap.
            if (!fifo_empty && (gap_q == '0) && (pix_count_q < CW'(FRAME_PIXELS))) begin
               fifo_pop    = 1'b1;
               we_d        = 1'b1;
               data_d      = fifo_rdata;
               pix_count_d = pix_count_q + CW'(1);
               gap_d       = GW'(WRITE_GAP - 1);
            end else if (gap_q != '0) begin
               gap_d = gap_q - GW'(1);
            end
            if (we_q && (pix_count_q == CW'(FRAME_PIXELS))) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == DONE);
   end

   assign we         = we_q;
   assign data_out   = data_q;
   assign pix_count  = pix_count_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_loader.sv
// Scoreboard bench for pixel_loader: three instances (gap 2, gap 4, pass-through) driven one at a time.
module tb_pixel_loader;

   localparam int unsigned NPIX = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, s_valid;
   logic [7:0] threshold, s_data;
   logic [1:0] sel;

   logic       start_v   [3];
   logic       s_valid_v [3];
   logic       s_ready_w [3];
   logic       we_w      [3];
   logic [7:0] data_w    [3];
   logic [6:0] pc_w      [3];
   logic       busy_w    [3];
   logic       fd_w      [3];

   logic       s_ready, we, busy, frame_done;
   logic [7:0] data_out;
   logic [6:0] pix_count;

   assign start_v[0]   = start && (sel == 2'd0);
   assign start_v[1]   = start && (sel == 2'd1);
   assign start_v[2]   = start && (sel == 2'd2);
   assign s_valid_v[0] = s_valid && (sel == 2'd0);
   assign s_valid_v[1] = s_valid && (sel == 2'd1);
   assign s_valid_v[2] = s_valid && (sel == 2'd2);

   always_comb begin
      s_ready    = s_ready_w[sel];
      we         = we_w[sel];
      data_out   = data_w[sel];
      pix_count  = pc_w[sel];
      busy       = busy_w[sel];
      frame_done = fd_w[sel];
   end

   pixel_loader #(.N(8), .pixelWidth(8), .FIFO_DEPTH(4), .WRITE_GAP(2), .BINARIZE(1)) dut_g2 (
      .clk(clk), .rst(rst), .start(start_v[0]), .threshold(threshold), .s_valid(s_valid_v[0]),
      .s_data(s_data), .s_ready(s_ready_w[0]), .we(we_w[0]), .data_out(data_w[0]),
      .pix_count(pc_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

   pixel_loader #(.N(8), .pixelWidth(8), .FIFO_DEPTH(4), .WRITE_GAP(4), .BINARIZE(1)) dut_g4 (
      .clk(clk), .rst(rst), .start(start_v[1]), .threshold(threshold), .s_valid(s_valid_v[1]),
      .s_data(s_data), .s_ready(s_ready_w[1]), .we(we_w[1]), .data_out(data_w[1]),
      .pix_count(pc_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

   pixel_loader #(.N(8), .pixelWidth(8), .FIFO_DEPTH(4), .WRITE_GAP(2), .BINARIZE(0)) dut_raw (
      .clk(clk), .rst(rst), .start(start_v[2]), .threshold(threshold), .s_valid(s_valid_v[2]),
      .s_data(s_data), .s_ready(s_ready_w[2]), .we(we_w[2]), .data_out(data_w[2]),
      .pix_count(pc_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   logic [7:0] exp_q [$];
   bit         mon_en, exact_gap;
   int         gap_exp, we_seen, fd_count, last_we_cyc, first_we_cyc;
   logic [7:0] pix_tab [7] = '{8'd200, 8'd128, 8'd127, 8'd0, 8'h5A, 8'd3, 8'd200};

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model_pix(input logic [7:0] p, input logic [7:0] thr, input bit bin);
      if (!bin) return p;
      return (p >= thr) ? 8'hFF : 8'h00;
   endfunction

   // Output-side checks, sampled mid-cycle on the falling edge.
   task automatic monitor();
      if (!mon_en) return;
      if (we) begin
         we_seen++;
         check_eq("we_has_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check_eq("data_out", 32'(data_out), 32'(exp_q.pop_front()));
         check_eq("pix_count_on_we", 32'(pix_count), 32'(we_seen));
         if (we_seen == 1) first_we_cyc = cyc;
         else if (exact_gap) check_eq("we_gap", 32'(cyc - last_we_cyc), 32'(gap_exp));
         else check_eq("we_gap_min", 32'((cyc - last_we_cyc) >= gap_exp), 32'd1);
         last_we_cyc = cyc;
      end
      if (frame_done) begin
         fd_count++;
         check_eq("frame_done_lag", 32'(cyc - last_we_cyc), 32'd1);
         check_eq("frame_done_pix_count", 32'(pix_count), 32'(NPIX));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_s_ready"},    32'(s_ready),    32'd0);
      check_eq({tag, "_we"},         32'(we),         32'd0);
      check_eq({tag, "_data_out"},   32'(data_out),   32'd0);
      check_eq({tag, "_pix_count"},  32'(pix_count),  32'd0);
      check_eq({tag, "_busy"},       32'(busy),       32'd0);
      check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   task automatic run_frame(input logic [7:0] thr, input int vpct, input bit exact,
                            input int abort_at, input bit poke);
      int idx     = 0;
      int guard   = 0;
      int acc_cyc = -1;
      bit acc;
      bit stall   = 1'b0;
      exp_q.delete();
      we_seen = 0; fd_count = 0; last_we_cyc = 0; first_we_cyc = 0;
      exact_gap = exact;
      gap_exp   = (sel == 2'd1) ? 4 : 2;
      threshold = thr;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check_eq("busy_rise", 32'(busy), 32'd1);
      check_eq("s_ready_first", 32'(s_ready), 32'd1);
      while ((idx < NPIX || we_seen < NPIX) && guard < 2000) begin
         if (abort_at > 0 && we_seen >= abort_at) break;
         start = poke && (idx == 5);
         if (poke && idx >= 5) threshold = 8'hFF;
         if (!s_valid && idx < NPIX && $urandom_range(99) < 32'(vpct)) begin
            s_valid = 1'b1;
            s_data  = (idx < 7) ? pix_tab[idx] : 8'($urandom);
         end
         acc = s_valid && s_ready;
         if (s_valid && !s_ready) stall = 1'b1;
         if (acc) begin
            exp_q.push_back(model_pix(s_data, thr, sel != 2'd2));
            if (acc_cyc < 0) acc_cyc = cyc;
            idx++;
         end
         tick();
         guard++;
         if (acc) begin
            s_valid = 1'b0;
            if (idx == NPIX) check_eq("s_ready_after_last", 32'(s_ready), 32'd0);
         end
      end
      start = 1'b0;
      check_eq("frame_within_budget", 32'(guard < 2000), 32'd1);
      if (abort_at > 0) return;
      if (exact) check_eq("first_strobe_latency", 32'(first_we_cyc - acc_cyc), 32'd2);
      if (sel == 2'd1) check_eq("fifo_full_stall", 32'(stall), 32'd1);
      guard = 0;
      while (fd_count == 0 && guard < 10) begin
         tick();
         guard++;
      end
      check_eq("frame_done_seen", 32'(fd_count), 32'd1);
      tick();
      tick();
      check_eq("frame_done_once", 32'(fd_count), 32'd1);
      check_eq("we_total", 32'(we_seen), 32'(NPIX));
      check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_s_ready", 32'(s_ready), 32'd0);
      check_eq("idle_pix_count_held", 32'(pix_count), 32'(NPIX));
   endtask

   initial begin
      sel = 2'd0; rst = 1'b1; start = 1'b0; s_valid = 1'b0;
      threshold = 8'd0; s_data = 8'd0; mon_en = 1'b0;
      exact_gap = 1'b0; gap_exp = 2;
      we_seen = 0; fd_count = 0; last_we_cyc = 0; first_we_cyc = 0;

      // Reset held with random inputs, including start.
      for (int i = 0; i < 3; i++) begin
         start     = 1'b1;
         threshold = 8'($urandom);
         s_valid   = 1'($urandom);
         s_data    = 8'($urandom);
         tick();
         check_reset("reset_hold");
      end
      rst = 1'b0; start = 1'b0; s_valid = 1'b0;
      tick();
      check_eq("start_during_reset_ignored", 32'(busy), 32'd0);
      mon_en = 1'b1;

      sel = 2'd0; run_frame(8'd128, 100, 1'b1, 0, 1'b0);
      sel = 2'd0; run_frame(8'd128, 40,  1'b0, 0, 1'b0);
      sel = 2'd1; run_frame(8'd128, 100, 1'b1, 0, 1'b0);

      // Reset mid-frame after 20 strobes, then a full frame with a low threshold.
      sel = 2'd0; run_frame(8'd128, 100, 1'b1, 20, 1'b0);
      rst = 1'b1;
      tick();
      check_reset("reset_mid_frame");
      rst = 1'b0; s_valid = 1'b0;
      exp_q.delete();
      repeat (3) tick();
      check_eq("no_frame_done_after_reset", 32'(fd_count), 32'd0);
      check_eq("idle_after_reset", 32'(busy), 32'd0);
      run_frame(8'd10, 100, 1'b1, 0, 1'b0);

      sel = 2'd0; run_frame(8'd128, 100, 1'b1, 0, 1'b1);
      sel = 2'd2; run_frame(8'd128, 100, 1'b1, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
